fetch_pc_predictor: RTL and testbench

Parametrised fetch-stage PC unit for the Y86 pipeline that owns the predicted-PC register. Selects `f_pc` from the predicted PC, the M-stage branch correction and the W-stage `ret` correction. Adds a bimodal branch-history table (BHT) of 2-bit counters and an optional return-address stack (RAS). Sits between the F pipeline register and instruction memory, and supplies prediction metadata that the pipeline carries down to M and W.

---
 rtl/y86_pkg.sv | 22 ++
 rtl/fetch_ras.sv | 57 +++++
 rtl/fetch_pc_predictor.sv | 118 +++++++++++
 tb/tb_fetch_pc_predictor.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the fetch-side predictor: instruction codes,
// the BHT counter type and the saturating 2-bit counter update.
package y86_pkg;

  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  typedef logic [1:0] bht_cnt_t;

  // Moves a 2-bit counter one step toward taken or not-taken, sticking at the ends
  function automatic bht_cnt_t bhtNext(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t res;
    if (taken) begin
      res = (cnt == 2'b11) ? cnt : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? cnt : cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/fetch_ras.sv
// Circular return-address stack. Once it is full, a push overwrites the oldest
// entry. i_clear empties the stack before that cycle's push or pop takes effect,
// and o_empty/o_full already reflect that clear.
module fetch_ras #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_pushData,
  output logic [ADDR_W-1:0] o_top,
  output logic              o_empty,
  output logic              o_full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  r_top;
  logic [CNT_W-1:0]  r_count;

  logic [CNT_W-1:0]  w_baseCount;
  logic [PTR_W-1:0]  w_topInc;
  logic [PTR_W-1:0]  w_topDec;

  assign w_baseCount = i_clear ? '0 : r_count;
  assign w_topInc    = r_top + PTR_W'(1);
  assign w_topDec    = r_top - PTR_W'(1);
  assign o_empty     = (w_baseCount == '0);
  assign o_full      = (w_baseCount == CNT_W'(RAS_DEPTH));
  assign o_top       = r_mem[r_top];

  // Pointer, occupancy and storage update: push wins over pop, and a pop from an empty stack is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_top   <= '0;
      r_count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push) begin
      r_top           <= w_topInc;
      r_mem[w_topInc] <= i_pushData;
      r_count         <= o_full ? w_baseCount : w_baseCount + CNT_W'(1);
    end else if (i_pop && !o_empty) begin
      r_top   <= w_topDec;
      r_count <= w_baseCount - CNT_W'(1);
    end else begin
      r_count <= w_baseCount;
    end
  end

endmodule

// File: rtl/fetch_pc_predictor.sv
// Fetch-stage PC unit: predicted-PC register, M/W correction muxing, bimodal BHT.
// Define FETCH_RAS_EN to add a return-address stack for ret prediction.
module fetch_pc_predictor
  import y86_pkg::*;
#(
  parameter int       ADDR_W      = 64,
  parameter int       BHT_ENTRIES = 16,
  parameter int       RAS_DEPTH   = 8,
  parameter bht_cnt_t CNT_INIT    = 2'b10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              F_stall,
  input  logic [3:0]        f_icode,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  input  logic [3:0]        M_icode,
  input  logic              M_Cnd,
  input  logic              M_predTaken,
  input  logic [ADDR_W-1:0] M_pc,
  input  logic [ADDR_W-1:0] M_valA,
  input  logic [ADDR_W-1:0] M_valC,
  input  logic [3:0]        W_icode,
  input  logic [ADDR_W-1:0] W_valM,
  input  logic [ADDR_W-1:0] W_predTarget,
  output logic [ADDR_W-1:0] f_pc,
  output logic              f_predTaken,
  output logic [ADDR_W-1:0] f_predTarget,
  output logic              f_redirect
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [ADDR_W-1:0] r_predPC;
  bht_cnt_t          r_bht [BHT_ENTRIES];

  logic              w_brMis;
  logic              w_retMis;
  logic [ADDR_W-1:0] w_brTarget;
  logic [IDX_W-1:0]  w_fIdx;
  logic [IDX_W-1:0]  w_mIdx;
  logic [ADDR_W-1:0] w_retPred;
  logic              w_unused;

  assign w_brMis    = (M_icode == IJXX) && (M_Cnd != M_predTaken);
  assign w_brTarget = M_Cnd ? M_valC : M_valA;
  assign f_redirect = w_brMis | w_retMis;
  assign f_pc       = w_brMis ? w_brTarget : (w_retMis ? W_valM : r_predPC);

  assign w_fIdx      = f_pc[IDX_W-1:0];
  assign w_mIdx      = M_pc[IDX_W-1:0];
  assign f_predTaken = (f_icode == IJXX) ? r_bht[w_fIdx][1] : 1'b0;

`ifdef FETCH_RAS_EN
  logic              w_rasPush;
  logic              w_rasPop;
  logic [ADDR_W-1:0] w_rasTop;
  logic              w_rasEmpty;
  logic              w_rasFull;

  assign w_retMis  = (W_icode == IRET) && (W_valM != W_predTarget);
  assign w_rasPush = (f_icode == ICALL) && !F_stall;
  assign w_rasPop  = (f_icode == IRET) && !F_stall;
  assign w_retPred = w_rasEmpty ? f_valP : w_rasTop;
  assign w_unused  = ^{M_pc[ADDR_W-1:IDX_W], w_rasFull};

  fetch_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_rasPush),
    .i_pop      (w_rasPop),
    .i_clear    (f_redirect),
    .i_pushData (f_valP),
    .o_top      (w_rasTop),
    .o_empty    (w_rasEmpty),
    .o_full     (w_rasFull)
  );
`else
  assign w_retMis  = (W_icode == IRET);
  assign w_retPred = f_valP;
  assign w_unused  = ^{M_pc[ADDR_W-1:IDX_W], W_predTarget};
`endif

  // Next-PC prediction from the instruction being fetched this cycle
  always_comb begin
    f_predTarget = f_valP;
    case (f_icode)
      IJXX:    f_predTarget = f_predTaken ? f_valC : f_valP;
      ICALL:   f_predTarget = f_valC;
      IRET:    f_predTarget = w_retPred;
      default: f_predTarget = f_valP;
    endcase
  end

  // Predicted-PC register, frozen while fetch is stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_predPC <= '0;
    end else if (!F_stall) begin
      r_predPC <= f_predTarget;
    end
  end

  // BHT training from the resolved M-stage jump, independent of fetch stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= CNT_INIT;
      end
    end else if (M_icode == IJXX) begin
      r_bht[w_mIdx] <= bhtNext(r_bht[w_mIdx], M_Cnd);
    end
  end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed self-checking bench for fetch_pc_predictor (default parameters).
// The RAS sections run only when FETCH_RAS_EN is defined.
module tb_fetch_pc_predictor;
  import y86_pkg::*;

  localparam int ADDR_W    = 64;
  localparam int RAS_DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              F_stall;
  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valC;
  logic [ADDR_W-1:0] f_valP;
  logic [3:0]        M_icode;
  logic              M_Cnd;
  logic              M_predTaken;
  logic [ADDR_W-1:0] M_pc;
  logic [ADDR_W-1:0] M_valA;
  logic [ADDR_W-1:0] M_valC;
  logic [3:0]        W_icode;
  logic [ADDR_W-1:0] W_valM;
  logic [ADDR_W-1:0] W_predTarget;
  logic [ADDR_W-1:0] f_pc;
  logic              f_predTaken;
  logic [ADDR_W-1:0] f_predTarget;
  logic              f_redirect;

  int checkCount = 0;
  int errorCount = 0;

  fetch_pc_predictor #(
    .ADDR_W      (ADDR_W),
    .BHT_ENTRIES (16),
    .RAS_DEPTH   (RAS_DEPTH),
    .CNT_INIT    (2'b10)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .F_stall      (F_stall),
    .f_icode      (f_icode),
    .f_valC       (f_valC),
    .f_valP       (f_valP),
    .M_icode      (M_icode),
    .M_Cnd        (M_Cnd),
    .M_predTaken  (M_predTaken),
    .M_pc         (M_pc),
    .M_valA       (M_valA),
    .M_valC       (M_valC),
    .W_icode      (W_icode),
    .W_valM       (W_valM),
    .W_predTarget (W_predTarget),
    .f_pc         (f_pc),
    .f_predTaken  (f_predTaken),
    .f_predTarget (f_predTarget),
    .f_redirect   (f_redirect)
  );

  // 10-time-unit clock
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle M and W stages so no correction or training happens
  task automatic idleBackEnd();
    M_icode = 4'h0; M_Cnd = 1'b0; M_predTaken = 1'b0;
    M_pc = '0; M_valA = '0; M_valC = '0;
    W_icode = 4'h0; W_valM = '0; W_predTarget = '0;
  endtask

  // Drive the fetch-side instruction fields and let them settle
  task automatic applyStimulus(input logic [3:0] icode, input logic [63:0] valC, input logic [63:0] valP);
    f_icode = icode;
    f_valC  = valC;
    f_valP  = valP;
    #1;
  endtask

  // Fetch a plain instruction whose fall-through is pc so predPC becomes pc
  task automatic moveTo(input logic [63:0] pc);
    applyStimulus(4'h1, 64'h0, pc);
    tick();
  endtask

  // Resolve a jXX in M with a correct prediction, training its BHT entry
  task automatic resolveBranch(input logic [63:0] pc, input logic cnd);
    M_icode = IJXX; M_pc = pc; M_Cnd = cnd; M_predTaken = cnd;
    tick();
    M_icode = 4'h0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    F_stall = 1'b0;
    idleBackEnd();
    applyStimulus(4'h1, 64'h0, 64'h0);
    #12;
    reset_n = 1'b1;
    tick();
    checkOutput("reset_pc", f_pc, 64'h0);
    checkOutput("reset_redirect", {63'h0, f_redirect}, 64'h0);

    // Asynchronous reset mid-run drops predPC back to zero
    moveTo(64'h40);
    checkOutput("predpc_0x40", f_pc, 64'h40);
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_pc", f_pc, 64'h0);
    checkOutput("async_reset_redirect", {63'h0, f_redirect}, 64'h0);
    #2;
    reset_n = 1'b1;
    tick();

    // Every BHT entry starts weakly taken
    for (int i = 0; i < 16; i++) begin
      moveTo(64'(i));
      applyStimulus(IJXX, 64'h500, 64'(i + 3));
      checkOutput($sformatf("bht_init_taken_%0d", i), {63'h0, f_predTaken}, 64'h1);
      checkOutput($sformatf("bht_init_target_%0d", i), f_predTarget, 64'h500);
    end

    // Train index 3 via M_pc=0x13 while fetch sits stalled on 0x23
    moveTo(64'h23);
    F_stall = 1'b1;
    applyStimulus(IJXX, 64'h500, 64'h2D);
    checkOutput("bht_idx3_start", {63'h0, f_predTaken}, 64'h1);
    resolveBranch(64'h13, 1'b0);
    checkOutput("bht_nt_once", {63'h0, f_predTaken}, 64'h0);
    resolveBranch(64'h13, 1'b0);
    checkOutput("bht_nt_twice", {63'h0, f_predTaken}, 64'h0);
    checkOutput("bht_nt_target", f_predTarget, 64'h2D);
    checkOutput("stall_holds_pc", f_pc, 64'h23);

    // Lower saturation: 00 stays 00, then 01, then 10 (old value seen in the write cycle)
    resolveBranch(64'h13, 1'b0);
    resolveBranch(64'h13, 1'b0);
    resolveBranch(64'h13, 1'b1);
    checkOutput("bht_sat_low", {63'h0, f_predTaken}, 64'h0);
    M_icode = IJXX; M_pc = 64'h13; M_Cnd = 1'b1; M_predTaken = 1'b1;
    #1;
    checkOutput("bht_same_cycle_old", {63'h0, f_predTaken}, 64'h0);
    tick();
    M_icode = 4'h0;
    checkOutput("bht_next_cycle_new", {63'h0, f_predTaken}, 64'h1);

    // Upper saturation: 10 -> 11 -> 11 -> 11, then two not-taken give 01
    resolveBranch(64'h13, 1'b1);
    resolveBranch(64'h13, 1'b1);
    resolveBranch(64'h13, 1'b1);
    resolveBranch(64'h13, 1'b0);
    checkOutput("bht_sat_high_10", {63'h0, f_predTaken}, 64'h1);
    resolveBranch(64'h13, 1'b0);
    checkOutput("bht_sat_high_01", {63'h0, f_predTaken}, 64'h0);
    F_stall = 1'b0;

    // Reset restores the trained entry to weakly taken
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    moveTo(64'h23);
    applyStimulus(IJXX, 64'h500, 64'h2D);
    checkOutput("reset_bht_idx3", {63'h0, f_predTaken}, 64'h1);

    // Branch mispredict (not taken) beats a same-cycle W ret
    M_icode = IJXX; M_predTaken = 1'b1; M_Cnd = 1'b0;
    M_valA = 64'h2A; M_valC = 64'h77; M_pc = 64'h60;
    W_icode = IRET; W_valM = 64'h99; W_predTarget = 64'h11;
    applyStimulus(4'h1, 64'h0, 64'h2C);
    checkOutput("brmis_nt_pc", f_pc, 64'h2A);
    checkOutput("brmis_nt_redirect", {63'h0, f_redirect}, 64'h1);
    tick();
    idleBackEnd();
    #1;
    checkOutput("brmis_successor_pc", f_pc, 64'h2C);
    checkOutput("brmis_successor_redirect", {63'h0, f_redirect}, 64'h0);

    // Branch mispredict in the taken direction goes to M_valC
    M_icode = IJXX; M_predTaken = 1'b0; M_Cnd = 1'b1;
    M_valA = 64'h2A; M_valC = 64'h77; M_pc = 64'h61;
    applyStimulus(4'h1, 64'h0, 64'h80);
    checkOutput("brmis_tk_pc", f_pc, 64'h77);
    tick();
    idleBackEnd();
    #1;
    checkOutput("brmis_tk_successor", f_pc, 64'h80);

    // W-stage ret with a matching carried prediction
    W_icode = IRET; W_valM = 64'h99; W_predTarget = 64'h99;
    applyStimulus(4'h1, 64'h0, 64'h90);
`ifdef FETCH_RAS_EN
    checkOutput("ret_match_redirect", {63'h0, f_redirect}, 64'h0);
    checkOutput("ret_match_pc", f_pc, 64'h80);
    W_predTarget = 64'h11;
    #1;
`endif
    checkOutput("ret_redirect", {63'h0, f_redirect}, 64'h1);
    checkOutput("ret_redirect_pc", f_pc, 64'h99);
    tick();
    idleBackEnd();
    #1;
    checkOutput("ret_successor", f_pc, 64'h90);

    // Call predicts its constant, then the ret predicts from the RAS or falls through
    applyStimulus(ICALL, 64'h200, 64'h99);
    checkOutput("call_target", f_predTarget, 64'h200);
    tick();
    checkOutput("call_next_pc", f_pc, 64'h200);
    applyStimulus(IRET, 64'h0, 64'h201);
`ifdef FETCH_RAS_EN
    checkOutput("ret_pred", f_predTarget, 64'h99);
`else
    checkOutput("ret_pred", f_predTarget, 64'h201);
`endif
    tick();

    // Stalled call: predPC and RAS held, M training still lands on index 5
    F_stall = 1'b1;
    M_icode = IJXX; M_pc = 64'h5; M_Cnd = 1'b0; M_predTaken = 1'b0;
    applyStimulus(ICALL, 64'h300, 64'h400);
    tick();
    idleBackEnd();
    F_stall = 1'b0;
`ifdef FETCH_RAS_EN
    checkOutput("stall_call_pc", f_pc, 64'h99);
`else
    checkOutput("stall_call_pc", f_pc, 64'h201);
`endif
    applyStimulus(IRET, 64'h0, 64'h555);
    checkOutput("stall_no_push", f_predTarget, 64'h555);
    tick();
    moveTo(64'h15);
    applyStimulus(IJXX, 64'h500, 64'h17);
    checkOutput("stall_bht_update", {63'h0, f_predTaken}, 64'h0);
    checkOutput("stall_bht_target", f_predTarget, 64'h17);

`ifdef FETCH_RAS_EN
    // Call/ret pair, then W confirms the prediction without a redirect
    applyStimulus(ICALL, 64'h1000, 64'h100);
    tick();
    applyStimulus(IRET, 64'h0, 64'h1001);
    checkOutput("ras_ret_pred", f_predTarget, 64'h100);
    tick();
    W_icode = IRET; W_valM = 64'h100; W_predTarget = 64'h100;
    applyStimulus(4'h1, 64'h0, 64'h104);
    checkOutput("ras_w_confirm", {63'h0, f_redirect}, 64'h0);
    tick();
    idleBackEnd();

    // Overflow: DEPTH+1 calls, then DEPTH+1 rets come back newest first
    for (int k = 1; k <= RAS_DEPTH + 1; k++) begin
      applyStimulus(ICALL, 64'h2000, 64'(16 * k));
      tick();
    end
    for (int k = 1; k <= RAS_DEPTH + 1; k++) begin
      applyStimulus(IRET, 64'h0, 64'(12288 + k));
      if (k <= RAS_DEPTH) begin
        checkOutput($sformatf("ras_ovf_ret_%0d", k), f_predTarget, 64'(16 * (RAS_DEPTH + 2 - k)));
      end else begin
        checkOutput("ras_ovf_empty", f_predTarget, 64'(12288 + k));
      end
      tick();
    end

    // A redirect clears the stack, then a call at the corrected PC leaves one entry
    applyStimulus(ICALL, 64'h2000, 64'h700);
    tick();
    M_icode = IJXX; M_predTaken = 1'b1; M_Cnd = 1'b0;
    M_valA = 64'h2A0; M_valC = 64'h0; M_pc = 64'h0;
    applyStimulus(ICALL, 64'h3000, 64'h710);
    checkOutput("ras_clear_pc", f_pc, 64'h2A0);
    tick();
    idleBackEnd();
    applyStimulus(IRET, 64'h0, 64'h3001);
    checkOutput("ras_clear_push", f_predTarget, 64'h710);
    tick();
    applyStimulus(IRET, 64'h0, 64'h4001);
    checkOutput("ras_clear_empty", f_predTarget, 64'h4001);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
